// File: rtl/tag_pkg.sv
// Shared types and constants for the rename-tag free pool.
//   tag_w        : tag width; tag 0 means "no tag", so the pool holds 2^tag_w - 1 tags
//   tag_t        : one rename tag
//   pool_state_e : pool controller state
package tag_pkg;

  localparam int tag_w = 6;
  localparam int DEPTH = 1 << tag_w;

  typedef logic [tag_w-1:0] tag_t;

  localparam tag_t TAG_NONE = '0;
  // Highest tag value; it is also the pool capacity and the last init-sweep value.
  localparam tag_t TAG_MAX  = '1;

  typedef enum logic {
    INIT,
    READY
  } pool_state_e;

endpackage

// File: rtl/tag_fifo_mem.sv
// Storage for the free-tag FIFO: 1R1W flop array with combinational read.
//   clk   : core clock
//   we    : write enable
//   waddr : write address
//   wdata : tag written at waddr
//   raddr : read address
//   rdata : tag stored at raddr (combinational)
module tag_fifo_mem
  import tag_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [tag_w-1:0] waddr,
  input  logic [tag_w-1:0] wdata,
  input  logic [tag_w-1:0] raddr,
  output logic [tag_w-1:0] rdata
);

  tag_t mem [DEPTH];

  // No reset: contents are rebuilt by the init sweep before they are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tag_free_pool.sv
// Free-list allocator for rename tags. Hands out one non-zero tag per cycle
// and takes back one retired tag per cycle; Flush rebuilds the pool to
// "all tags free" with a sequential init sweep.
//   clk       : core clock
//   rst       : asynchronous active-low reset
//   Available : a tag can be popped this cycle
//   Enable    : consumer wants a tag (pop happens on Enable & Available)
//   Tag       : current head tag, valid while Available
//   RelValid  : a tag is being returned this cycle
//   RelTag    : the returned tag
//   Flush     : discard all state and re-initialise the pool
//   FreeCount : number of free tags
//   Err       : sticky illegal-release flag (tag 0 or release while full)
//
// state | meaning
// INIT  | sweep writes tags 1..2^tag_w-1 into the FIFO; no pops, releases dropped
// READY | normal pop/release operation
module tag_free_pool
  import tag_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic             Available,
  input  logic             Enable,
  output logic [tag_w-1:0] Tag,
  input  logic             RelValid,
  input  logic [tag_w-1:0] RelTag,
  input  logic             Flush,
  output logic [tag_w-1:0] FreeCount,
  output logic             Err
);

  pool_state_e state, state_nxt;

  tag_t init_cnt;
  tag_t rd_ptr;
  tag_t wr_ptr;
  tag_t count;
  logic err_q;

  logic init_last;
  logic full;
  logic pop;
  logic push;
  logic rel_bad;

  logic mem_we;
  tag_t mem_waddr;
  tag_t mem_wdata;
  tag_t mem_rdata;

  assign init_last = (init_cnt == TAG_MAX);
  assign full      = (count == TAG_MAX);

  // count is held at zero outside READY, but the state term keeps INIT explicit.
  assign Available = (state == READY) && (count != '0);

  // A Flush cycle cancels any pop or push presented alongside it.
  assign pop     = Enable && Available && !Flush;
  assign push    = (state == READY) && RelValid && (RelTag != TAG_NONE) && !full && !Flush;
  assign rel_bad = (state == READY) && RelValid && ((RelTag == TAG_NONE) || full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT:    if (init_last) state_nxt = READY;
        READY:   state_nxt = READY;
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt <= tag_t'(1);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else if (Flush) begin
      init_cnt <= tag_t'(1);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else if (state == INIT) begin
      if (init_last) begin
        // Sweep filled mem[0..TAG_MAX-1]; the next release lands in the spare slot.
        rd_ptr <= '0;
        wr_ptr <= TAG_MAX;
        count  <= TAG_MAX;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !push) begin
        count <= count - 1'b1;
      end else if (push && !pop) begin
        count <= count + 1'b1;
      end
      if (rel_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  // Write port shared between the init sweep and releases.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = RelTag;
    if (state == INIT) begin
      mem_we    = !Flush;
      mem_waddr = init_cnt - 1'b1;
      mem_wdata = init_cnt;
    end else begin
      mem_we    = push;
    end
  end

  tag_fifo_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign Tag       = Available ? mem_rdata : TAG_NONE;
  assign FreeCount = count;
  assign Err       = err_q;

endmodule

// File: tb/tb_tag_free_pool.sv
// Testbench for tag_free_pool. Stimulus pushes expected tags into a queue;
// a monitor pops and compares on every Enable & Available cycle.
module tb_tag_free_pool;

  logic       clk;
  logic       rst;
  logic       Available;
  logic       Enable;
  logic [5:0] Tag;
  logic       RelValid;
  logic [5:0] RelTag;
  logic       Flush;
  logic [5:0] FreeCount;
  logic       Err;

  int checks = 0;
  int errors = 0;

  logic [5:0] expq [$];
  logic [5:0] mon_exp;

  tag_free_pool dut (
    .clk       (clk),
    .rst       (rst),
    .Available (Available),
    .Enable    (Enable),
    .Tag       (Tag),
    .RelValid  (RelValid),
    .RelTag    (RelTag),
    .Flush     (Flush),
    .FreeCount (FreeCount),
    .Err       (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot = 1 time unit after a rising edge: outputs reflect that edge,
  // inputs driven here apply at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_avail(output int n);
    n = 0;
    while (!Available && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_sweep();
    for (int i = 1; i <= 63; i++) expq.push_back(6'(i));
  endtask

  // Scoreboard monitor: the DUT consumes a tag on each Enable & Available edge.
  always @(negedge clk) begin
    if (Available && Enable) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got tag %0d, expected no pop", Tag);
      end else begin
        mon_exp = expq.pop_front();
        if (Tag !== mon_exp) begin
          errors++;
          $display("FAIL pop_tag: got %0d, expected %0d (t=%0t)", Tag, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; Enable = 1'b0; RelValid = 1'b0; RelTag = '0; Flush = 1'b0;
    tick(); tick();
    check("rst_available", Available, 0);
    check("rst_tag", Tag, 0);
    check("rst_freecount", FreeCount, 0);
    check("rst_err", Err, 0);

    // Reset release with Enable held: 63 idle cycles, then tags 1..63 back to back.
    expect_sweep();
    rst = 1'b1; Enable = 1'b1;
    wait_avail(n);
    check("init_latency_reset", n, 63);
    repeat (63) tick();
    check("drain_available", Available, 0);
    check("drain_freecount", FreeCount, 0);
    check("drain_queue_left", expq.size(), 0);

    // Drained pool, release 17: visible next cycle, gone after the pop.
    RelValid = 1'b1; RelTag = 6'd17; expq.push_back(6'd17);
    tick();
    RelValid = 1'b0;
    check("rel17_available", Available, 1);
    check("rel17_tag", Tag, 17);
    check("rel17_freecount", FreeCount, 1);
    tick();
    check("rel17_after_pop", Available, 0);
    check("rel17_queue_left", expq.size(), 0);

    // Fill to 5, then 200 cycles of simultaneous pop and release.
    Enable = 1'b0; RelValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      RelTag = 6'(40 + i); expq.push_back(6'(40 + i));
      tick();
    end
    check("fill5_freecount", FreeCount, 5);
    Enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) check("steady_freecount", FreeCount, 5);
      RelTag = 6'((i % 63) + 1); expq.push_back(6'((i % 63) + 1));
      tick();
    end
    check("steady_freecount_end", FreeCount, 5);
    RelValid = 1'b0;
    repeat (5) tick();
    check("steady_drain_available", Available, 0);
    check("steady_queue_left", expq.size(), 0);

    // Flush to a full pool, then an illegal release while full.
    Enable = 1'b0; Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush1_available", Available, 0);
    wait_avail(n);
    check("init_latency_flush1", n, 63);
    check("full_freecount", FreeCount, 63);
    RelValid = 1'b1; RelTag = 6'd9;
    tick();
    RelValid = 1'b0;
    check("full_rel_err", Err, 1);
    check("full_rel_dropped", FreeCount, 63);

    // Flush clears Err; releases during INIT are dropped silently.
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_clears_err", Err, 0);
    RelValid = 1'b1; RelTag = 6'd5;
    wait_avail(n);
    RelValid = 1'b0;
    check("init_latency_flush2", n, 63);
    check("init_rel_no_err", Err, 0);
    check("init_rel_freecount", FreeCount, 63);

    // Pop 43 to reach 20 free, then release tag 0.
    for (int i = 1; i <= 43; i++) expq.push_back(6'(i));
    Enable = 1'b1;
    repeat (43) tick();
    Enable = 1'b0;
    check("pop43_freecount", FreeCount, 20);
    RelValid = 1'b1; RelTag = 6'd0;
    tick();
    RelValid = 1'b0;
    check("rel0_err", Err, 1);
    check("rel0_freecount", FreeCount, 20);

    // Flush at 20 free with a release in the flush cycle and throughout INIT.
    Flush = 1'b1; RelValid = 1'b1; RelTag = 6'd33;
    tick();
    Flush = 1'b0; RelTag = 6'd34; Enable = 1'b1;
    check("flush3_available", Available, 0);
    check("flush3_freecount", FreeCount, 0);
    check("flush3_err", Err, 0);
    expect_sweep();
    wait_avail(n);
    RelValid = 1'b0;
    check("init_latency_flush3", n, 63);
    repeat (63) tick();
    check("flush3_drain_available", Available, 0);
    check("flush3_queue_left", expq.size(), 0);
    check("flush3_err_end", Err, 0);

    // Async reset mid-READY with nonzero outputs.
    Enable = 1'b0; RelValid = 1'b1; RelTag = 6'd0;
    tick();
    RelTag = 6'd7;
    tick();
    RelValid = 1'b0;
    check("pre_rst_available", Available, 1);
    check("pre_rst_freecount", FreeCount, 1);
    check("pre_rst_err", Err, 1);
    rst = 1'b0;
    #1;
    check("async_rst_available", Available, 0);
    check("async_rst_tag", Tag, 0);
    check("async_rst_freecount", FreeCount, 0);
    check("async_rst_err", Err, 0);
    tick();
    rst = 1'b1;

    // Async reset mid-INIT restarts the full sweep.
    repeat (30) tick();
    check("mid_init_available", Available, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1; Enable = 1'b1;
    expect_sweep();
    wait_avail(n);
    check("init_latency_rst_mid_init", n, 63);
    repeat (63) tick();
    check("final_available", Available, 0);
    check("final_freecount", FreeCount, 0);
    check("final_queue_left", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
